// File: rtl/k007232_host_wr_if.sv
// k007232_host_wr_if: host write-request handshake plus the 007232 chip-side bus.
interface k007232_host_wr_if;
    logic       REQ_VALID;
    logic       REQ_READY;
    logic [3:0] REQ_REG;
    logic [7:0] REQ_DATA;
    logic [3:0] AB;
    logic [7:0] DB;
    logic       DB_OE;
    logic       DACS;
    logic       NRCS;
    logic       NRD;
    logic       BUSY;

    modport master (
        output REQ_VALID, REQ_REG, REQ_DATA,
        input  REQ_READY, AB, DB, DB_OE, DACS, NRCS, NRD, BUSY
    );

    modport slave (
        input  REQ_VALID, REQ_REG, REQ_DATA,
        output REQ_READY, AB, DB, DB_OE, DACS, NRCS, NRD, BUSY
    );
endinterface

// File: rtl/k007232_host_wr.sv
// k007232_host_wr: buffers host register writes and replays them to the 007232 with setup/strobe/hold timing.
// Define HOSTWR_FIFO_EN for a 4-entry request FIFO; otherwise a single holding register is used.
module k007232_host_wr #(
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1
) (
    input  logic CLK,
    input  logic NRES,
    k007232_host_wr_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
    localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);
    localparam logic [3:0] HOLD_LD   = (HOLD_CYC > 0) ? 4'(HOLD_CYC - 1) : 4'd0;

    state_t     state;
    logic [3:0] cnt;
    logic [3:0] ab_q;
    logic [7:0] db_q;
    logic       db_oe_q;
    logic       dacs_q;
    logic       busy_q;
    logic       ready;
    logic       push;
    logic       pop;
    logic       has_entry;
    logic       pending_nxt;
    logic       idle_nxt;
    logic [3:0] head_reg;
    logic [7:0] head_data;

    assign push = bus.REQ_VALID && ready;
    assign pop  = (state == IDLE) && has_entry;

    // True when the FSM will be sitting in IDLE after the coming edge.
    assign idle_nxt = ((state == IDLE) && !pop)
                   || ((state == STROBE) && (cnt == 4'd0) && (HOLD_CYC == 0))
                   || ((state == HOLD) && (cnt == 4'd0));

`ifdef HOSTWR_FIFO_EN
    logic [11:0] mem [4];
    logic [1:0]  wr_ptr;
    logic [1:0]  rd_ptr;
    logic [2:0]  count;
    logic [2:0]  count_nxt;

    always_comb begin
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + 3'd1;
        end else if (pop && !push) begin
            count_nxt = count - 3'd1;
        end
    end

    assign has_entry             = (count != 3'd0);
    assign pending_nxt           = (count_nxt != 3'd0);
    assign {head_reg, head_data} = mem[rd_ptr];

    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= {bus.REQ_REG, bus.REQ_DATA};
        end
    end

    always_ff @(posedge CLK or negedge NRES) begin
        if (!NRES) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            count  <= 3'd0;
            ready  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            count <= count_nxt;
            ready <= (count_nxt != 3'd4);
        end
    end
`else
    logic [11:0] hold_q;
    logic        hold_valid;

    assign has_entry             = hold_valid;
    assign pending_nxt           = push || (hold_valid && !pop);
    assign {head_reg, head_data} = hold_q;

    // Ready only reopens once the previous write has fully drained back to IDLE.
    always_ff @(posedge CLK or negedge NRES) begin
        if (!NRES) begin
            hold_q     <= 12'd0;
            hold_valid <= 1'b0;
            ready      <= 1'b0;
        end else begin
            if (push) begin
                hold_q     <= {bus.REQ_REG, bus.REQ_DATA};
                hold_valid <= 1'b1;
            end else if (pop) begin
                hold_valid <= 1'b0;
            end
            ready <= idle_nxt && !pending_nxt;
        end
    end
`endif

    always_ff @(posedge CLK or negedge NRES) begin
        if (!NRES) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            ab_q    <= 4'd0;
            db_q    <= 8'd0;
            db_oe_q <= 1'b0;
            dacs_q  <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            busy_q <= pending_nxt || !idle_nxt;
            case (state)
                IDLE: begin
                    if (has_entry) begin
                        ab_q    <= {head_reg[3:1], ~head_reg[0]};
                        db_q    <= head_data;
                        db_oe_q <= 1'b1;
                        cnt     <= SETUP_LD;
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt == 4'd0) begin
                        dacs_q <= 1'b0;
                        cnt    <= STROBE_LD;
                        state  <= STROBE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                STROBE: begin
                    if (cnt == 4'd0) begin
                        dacs_q <= 1'b1;
                        if (HOLD_CYC == 0) begin
                            db_oe_q <= 1'b0;
                            state   <= IDLE;
                        end else begin
                            cnt   <= HOLD_LD;
                            state <= HOLD;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                HOLD: begin
                    if (cnt == 4'd0) begin
                        db_oe_q <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.REQ_READY = ready;
    assign bus.AB        = ab_q;
    assign bus.DB        = db_q;
    assign bus.DB_OE     = db_oe_q;
    assign bus.DACS      = dacs_q;
    assign bus.BUSY      = busy_q;
    assign bus.NRCS      = 1'b1;
    assign bus.NRD       = 1'b0;
endmodule

// File: tb/tb_k007232_host_wr.sv
// tb_k007232_host_wr: directed bench for k007232_host_wr with default timing (1/2/1);
// follows HOSTWR_FIFO_EN to pick FIFO or holding-register expectations.
module tb_k007232_host_wr;
`ifdef HOSTWR_FIFO_EN
    localparam int SPACING = 5;
`else
    localparam int SPACING = 6;
`endif

    logic CLK;
    logic NRES;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    k007232_host_wr_if bus ();

    k007232_host_wr dut (
        .CLK  (CLK),
        .NRES (NRES),
        .bus  (bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    // Strobe log plus running invariant/busy violation counters.
    logic       prev_dacs = 1'b1;
    int         ns = 0;
    int         inv_bad = 0;
    int         busy_drop = 0;
    logic       busy_watch = 1'b0;
    logic [3:0] s_ab   [16];
    logic [7:0] s_db   [16];
    int         s_fall [16];
    int         s_len  [16];

    always @(negedge CLK) begin
        prev_dacs <= bus.DACS;
        if (prev_dacs === 1'b1 && bus.DACS === 1'b0 && ns < 16) begin
            s_ab[ns]   <= bus.AB;
            s_db[ns]   <= bus.DB;
            s_fall[ns] <= cyc;
        end
        if (prev_dacs === 1'b0 && bus.DACS === 1'b1 && ns < 16) begin
            s_len[ns] <= cyc - s_fall[ns];
            ns        <= ns + 1;
        end
        if (bus.NRCS !== 1'b1 || bus.NRD !== 1'b0 || (bus.DACS === 1'b0 && bus.DB_OE !== 1'b1)) begin
            inv_bad <= inv_bad + 1;
        end
        if (busy_watch && bus.BUSY !== 1'b1) begin
            busy_drop <= busy_drop + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge, with REQ_VALID still high.
    task automatic applyStimulus(input logic [3:0] r, input logic [7:0] d);
        int n = 0;
        bus.REQ_VALID = 1'b1;
        bus.REQ_REG   = r;
        bus.REQ_DATA  = d;
        while (bus.REQ_READY !== 1'b1 && n < 60) begin
            @(negedge CLK);
            n++;
        end
        checkOutput("accept_ready", 16'(bus.REQ_READY), 16'd1);
        @(negedge CLK);
    endtask

    task automatic waitStrobes(input int target, input string tag);
        int n = 0;
        while (!(ns >= target && bus.DACS === 1'b1) && n < 400) begin
            @(negedge CLK);
            #1;
            n++;
        end
        checkOutput(tag, 16'(ns), 16'(target));
    endtask

    logic [3:0] t2_reg  [4] = '{4'd1, 4'd2, 4'd3, 4'd13};
    logic [7:0] t2_data [4] = '{8'h0F, 8'h00, 8'h00, 8'h01};
    logic [3:0] t2_ab   [4] = '{4'b0000, 4'b0011, 4'b0010, 4'b1100};
    logic [3:0] t3_reg  [6] = '{4'd4, 4'd7, 4'd9, 4'd14, 4'd15, 4'd6};
    logic [3:0] t3_ab   [6] = '{4'b0101, 4'b0110, 4'b1000, 4'b1111, 4'b1110, 4'b0111};

    initial begin
        int base;
        int n;
        NRES          = 1'b0;
        bus.REQ_VALID = 1'b0;
        bus.REQ_REG   = 4'd0;
        bus.REQ_DATA  = 8'd0;

        // Reset state
        @(negedge CLK);
        checkOutput("rst_dacs",  16'(bus.DACS),      16'd1);
        checkOutput("rst_db_oe", 16'(bus.DB_OE),     16'd0);
        checkOutput("rst_ab",    16'(bus.AB),        16'd0);
        checkOutput("rst_db",    16'(bus.DB),        16'd0);
        checkOutput("rst_busy",  16'(bus.BUSY),      16'd0);
        checkOutput("rst_ready", 16'(bus.REQ_READY), 16'd0);
        @(negedge CLK);
        NRES = 1'b1;
        #1;
        checkOutput("ready_before_edge", 16'(bus.REQ_READY), 16'd0);
        @(negedge CLK);
        checkOutput("ready_after_reset", 16'(bus.REQ_READY), 16'd1);

        // Single write reg0/F8
        $display("[TB] single write reg0/F8");
        applyStimulus(4'd0, 8'hF8);
        bus.REQ_VALID = 1'b0;
`ifdef HOSTWR_FIFO_EN
        checkOutput("t1_e0_ready", 16'(bus.REQ_READY), 16'd1);
`else
        checkOutput("t1_e0_ready", 16'(bus.REQ_READY), 16'd0);
`endif
        checkOutput("t1_e0_busy",  16'(bus.BUSY),  16'd1);
        checkOutput("t1_e0_db_oe", 16'(bus.DB_OE), 16'd0);
        checkOutput("t1_e0_dacs",  16'(bus.DACS),  16'd1);
        @(negedge CLK);
        checkOutput("t1_e1_ab",    16'(bus.AB),    16'h0001);
        checkOutput("t1_e1_db",    16'(bus.DB),    16'h00F8);
        checkOutput("t1_e1_db_oe", 16'(bus.DB_OE), 16'd1);
        checkOutput("t1_e1_dacs",  16'(bus.DACS),  16'd1);
        @(negedge CLK);
        checkOutput("t1_e2_dacs",  16'(bus.DACS),  16'd0);
        @(negedge CLK);
        checkOutput("t1_e3_dacs",  16'(bus.DACS),  16'd0);
        @(negedge CLK);
        checkOutput("t1_e4_dacs",  16'(bus.DACS),  16'd1);
        checkOutput("t1_e4_db_oe", 16'(bus.DB_OE), 16'd1);
        checkOutput("t1_e4_busy",  16'(bus.BUSY),  16'd1);
        @(negedge CLK);
        checkOutput("t1_e5_db_oe", 16'(bus.DB_OE), 16'd0);
        checkOutput("t1_e5_ab",    16'(bus.AB),    16'h0001);
        checkOutput("t1_e5_db",    16'(bus.DB),    16'h00F8);
        checkOutput("t1_e5_busy",  16'(bus.BUSY),  16'd0);
        checkOutput("t1_e5_ready", 16'(bus.REQ_READY), 16'd1);
        #1;
        checkOutput("t1_strobe_len", 16'(s_len[ns - 1]), 16'd2);

        // Back-to-back writes reg1, reg2, reg3, reg13
        $display("[TB] back-to-back four writes");
        base = ns;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(t2_reg[i], t2_data[i]);
            busy_watch = 1'b1;
        end
        bus.REQ_VALID = 1'b0;
        waitStrobes(base + 4, "t2_strobe_count");
        busy_watch = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checkOutput("t2_ab",  16'(s_ab[base + i]),  16'(t2_ab[i]));
            checkOutput("t2_db",  16'(s_db[base + i]),  16'(t2_data[i]));
            checkOutput("t2_len", 16'(s_len[base + i]), 16'd2);
            if (i > 0) begin
                checkOutput("t2_spacing", 16'(s_fall[base + i] - s_fall[base + i - 1]), 16'(SPACING));
            end
        end
`ifdef HOSTWR_FIFO_EN
        checkOutput("t2_busy_throughout", 16'(busy_drop), 16'd0);
`endif
        repeat (4) @(negedge CLK);

        // Six writes with REQ_VALID held; includes regs 14 and 15
        $display("[TB] six held writes");
        base = ns;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(t3_reg[i], 8'hA0 + 8'(i));
`ifdef HOSTWR_FIFO_EN
            if (i == 4) begin
                checkOutput("t3_ready_full", 16'(bus.REQ_READY), 16'd0);
            end
`endif
        end
        bus.REQ_VALID = 1'b0;
        waitStrobes(base + 6, "t3_strobe_count");
        for (int i = 0; i < 6; i++) begin
            checkOutput("t3_ab", 16'(s_ab[base + i]), 16'(t3_ab[i]));
            checkOutput("t3_db", 16'(s_db[base + i]), 16'(8'hA0 + 8'(i)));
            if (i > 0) begin
                checkOutput("t3_spacing", 16'(s_fall[base + i] - s_fall[base + i - 1]), 16'(SPACING));
            end
        end
        repeat (8) @(negedge CLK);
        #1;
        checkOutput("t3_no_extra", 16'(ns), 16'(base + 6));

        // Reset during the strobe of reg5/00
        $display("[TB] reset mid-strobe");
        applyStimulus(4'd5, 8'h00);
`ifdef HOSTWR_FIFO_EN
        applyStimulus(4'd8, 8'h33);
`endif
        bus.REQ_VALID = 1'b0;
        n = 0;
        while (bus.DACS !== 1'b0 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        checkOutput("t4_strobe_started", 16'(bus.DACS), 16'd0);
        checkOutput("t4_pre_ab", 16'(bus.AB), 16'b0100);
        #2;
        NRES = 1'b0;
        #1;
        checkOutput("t4_dacs",  16'(bus.DACS),      16'd1);
        checkOutput("t4_db_oe", 16'(bus.DB_OE),     16'd0);
        checkOutput("t4_ab",    16'(bus.AB),        16'd0);
        checkOutput("t4_db",    16'(bus.DB),        16'd0);
        checkOutput("t4_busy",  16'(bus.BUSY),      16'd0);
        checkOutput("t4_ready", 16'(bus.REQ_READY), 16'd0);
        repeat (3) @(negedge CLK);
        #1;
        base = ns;
        NRES = 1'b1;
        repeat (30) @(negedge CLK);
        #1;
        checkOutput("t4_no_strobe_after", 16'(ns), 16'(base));
        checkOutput("t4_busy_after",      16'(bus.BUSY), 16'd0);
        checkOutput("t4_ready_after",     16'(bus.REQ_READY), 16'd1);
        checkOutput("invariants", 16'(inv_bad), 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
